pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000 (XLEN wide): PC value loaded at reset.
REQ-003 SHALL have parameter IALIGN, default 4: instruction alignment in bytes; legal values are 2 and 4 only.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_stall, input, 1: hold the current PC.
REQ-007 SHALL have port i_ready, input, 1: fetch stage accepts o_addr this cycle.
REQ-008 SHALL have port i_redirect, input, 1: taken branch or jump.
REQ-009 SHALL have port i_target, input, XLEN: redirect destination.
REQ-010 SHALL have port i_trap, input, 1: exception or interrupt entry.
REQ-011 SHALL have port i_trapVec, input, XLEN: trap handler address.
REQ-012 SHALL have port i_instLen, input, 1: 1 = 4-byte instruction, 0 = 2-byte; ignored when IALIGN=4.
REQ-013 SHALL have port o_addr, output, XLEN: current fetch PC.
REQ-014 SHALL have port o_valid, output, 1: o_addr is a valid fetch request.
REQ-015 SHALL have port o_misaligned, output, 1: one-cycle pulse on a misaligned redirect.
REQ-016 SHALL have port o_halted, output, 1: high while in HALT.

Function
REQ-017 SHALL implement an FSM with states BOOT, RUN and HALT.
REQ-018 BOOT SHALL last exactly one cycle with o_valid=0, then move to RUN.
REQ-019 In RUN, o_valid SHALL be 1.
REQ-020 Accept is defined as o_valid & i_ready & ~i_stall; on accept, o_addr SHALL advance by step at the next edge.
REQ-021 step SHALL be 4 when IALIGN=4; when IALIGN=2, step SHALL be 4 if i_instLen=1, else 2.
REQ-022 The sum SHALL wrap modulo 2^XLEN (0xFFFF_FFFC+4 -> 0x0000_0000) with no flag raised.
REQ-023 Without accept and without trap/redirect, o_addr SHALL hold its value (stall or backpressure).
REQ-024 Next-PC priority SHALL be: trap > redirect > accept > hold.
REQ-025 Trap and redirect SHALL take effect at the next edge regardless of i_stall and i_ready.
REQ-026 On trap, o_addr SHALL load i_trapVec with its low log2(IALIGN) bits forced to 0, and the state SHALL become RUN; this applies from any state.
REQ-027 On an aligned redirect (i_target mod IALIGN == 0) in BOOT or RUN, o_addr SHALL load i_target and the state SHALL become RUN.
REQ-028 On a misaligned redirect in BOOT or RUN, o_addr SHALL hold, o_misaligned SHALL be 1 for exactly the following cycle, and the state SHALL become HALT.
REQ-029 In HALT, o_valid SHALL be 0, o_halted SHALL be 1, and redirect and accept SHALL be ignored; only i_trap exits HALT.
REQ-030 When trap and a misaligned redirect coincide, the trap SHALL win and o_misaligned SHALL stay 0.
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 While i_reset_n=0, the block SHALL be held in reset asynchronously: o_addr=RESET_VECTOR, state=BOOT, o_valid=0, o_misaligned=0, o_halted=0.
REQ-033 Reset asserted mid-operation, including in HALT, SHALL override all other inputs immediately, with no clock edge required.
REQ-034 After deassertion, the first rising edge SHALL move BOOT->RUN; o_addr SHALL still equal RESET_VECTOR in the first RUN cycle.

Structure
REQ-035 The package riscv_pkg SHALL hold pc_state_e (BOOT/RUN/HALT), XLEN_DEFAULT and the IALIGN legal-value constants.
REQ-036 A sub-module pc_next SHALL compute the combinational next PC (step, priority mux, alignment check).
REQ-037 pc_unit SHALL hold the registers and the FSM.
REQ-038 An elaboration-time assertion SHALL reject any IALIGN value other than 2 or 4.

Verification
REQ-039 Reset then boot: hold i_reset_n=0, release, i_ready=1 -> o_valid=0 for one cycle, then o_addr sequence 0x0, 0x4, 0x8.
REQ-040 Stall and backpressure: at o_addr=0x8, drive i_stall=1 for 2 cycles, then i_ready=0 for 2 cycles -> o_addr stays 0x8 for all 4 cycles, then moves to 0xC.
REQ-041 Redirect beats stall: i_stall=1, i_redirect=1, i_target=0x40 -> o_addr=0x40 next cycle; a simultaneous i_trap=1 with i_trapVec=0x103 gives o_addr=0x100 instead.
REQ-042 Misaligned redirect: IALIGN=4, i_target=0x42 -> o_misaligned=1 for one cycle, o_halted=1, o_valid=0, o_addr held; then i_trap with i_trapVec=0x200 -> RUN at 0x200.
REQ-043 Compressed steps with wrap: IALIGN=2, redirect to 0xFFFF_FFFA, then i_instLen=0, then 1 -> o_addr 0xFFFF_FFFA, 0xFFFF_FFFC, 0x0000_0000.
REQ-044 Asynchronous reset: in HALT, pulse i_reset_n low between clock edges -> o_addr=RESET_VECTOR and o_halted=0 immediately, before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch-PC logic.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int IALIGN_HALF  = 2;
  localparam int IALIGN_WORD  = 4;

  typedef enum logic [1:0] {
    PC_BOOT = 2'b00,
    PC_RUN  = 2'b01,
    PC_HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC: step selection, trap/redirect/accept priority and target alignment check.
module pc_next
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = IALIGN_WORD
) (
  input  pc_state_e        state,
  input  logic [XLEN-1:0]  pc,
  input  logic             valid,
  input  logic             stall,
  input  logic             ready,
  input  logic             redirect,
  input  logic [XLEN-1:0]  target,
  input  logic             trap,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             inst_len,
  output logic [XLEN-1:0]  next_pc,
  output pc_state_e        next_state,
  output logic             next_misaligned
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);

  function automatic logic [XLEN-1:0] pc_step(input logic len4);
    if (IALIGN == IALIGN_WORD || len4) return XLEN'(4);
    else                               return XLEN'(2);
  endfunction

  logic accept;
  logic target_aligned;

  assign accept         = valid & ready & ~stall;
  assign target_aligned = ((target & LOW_MASK) == '0);

  // Priority: trap > redirect > accept > hold; HALT ignores everything but trap.
  always_comb begin
    next_pc         = pc;
    next_state      = state;
    next_misaligned = 1'b0;
    if (trap) begin
      next_pc    = trap_vec & ~LOW_MASK;
      next_state = PC_RUN;
    end else if (state != PC_HALT) begin
      if (redirect) begin
        if (target_aligned) begin
          next_pc    = target;
          next_state = PC_RUN;
        end else begin
          next_state      = PC_HALT;
          next_misaligned = 1'b1;
        end
      end else begin
        if (accept) next_pc = pc + pc_step(inst_len);
        next_state = PC_RUN;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: BOOT/RUN/HALT control with fully registered outputs.
module pc_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int              IALIGN       = IALIGN_WORD
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_stall,
  input  logic             i_ready,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_target,
  input  logic             i_trap,
  input  logic [XLEN-1:0]  i_trapVec,
  input  logic             i_instLen,
  output logic [XLEN-1:0]  o_addr,
  output logic             o_valid,
  output logic             o_misaligned,
  output logic             o_halted
);

  generate
    if (IALIGN != IALIGN_HALF && IALIGN != IALIGN_WORD) begin : g_bad_ialign
      $error("pc_unit: IALIGN must be 2 or 4");
    end
  endgenerate

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            misaligned_d;

  pc_next #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_pc_next (
    .state           (state_q),
    .pc              (pc_q),
    .valid           (o_valid),
    .stall           (i_stall),
    .ready           (i_ready),
    .redirect        (i_redirect),
    .target          (i_target),
    .trap            (i_trap),
    .trap_vec        (i_trapVec),
    .inst_len        (i_instLen),
    .next_pc         (pc_d),
    .next_state      (state_d),
    .next_misaligned (misaligned_d)
  );

  // Status flags are registered from the next state so they line up with o_addr.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q         <= RESET_VECTOR;
      state_q      <= PC_BOOT;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      o_halted     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      o_valid      <= (state_d == PC_RUN);
      o_misaligned <= misaligned_d;
      o_halted     <= (state_d == PC_HALT);
    end
  end

  assign o_addr = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: an IALIGN=4 and an IALIGN=2 instance share stimulus and are checked against a per-instance model.
module tb_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_target = 32'h0;
  logic        i_trap = 1'b0;
  logic [31:0] i_trapVec = 32'h0;
  logic        i_instLen = 1'b1;

  logic [31:0] addr_o [2];
  logic        valid_o [2];
  logic        mis_o [2];
  logic        halt_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4)) u_dut4 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stall(i_stall), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_target(i_target), .i_trap(i_trap), .i_trapVec(i_trapVec),
    .i_instLen(i_instLen), .o_addr(addr_o[0]), .o_valid(valid_o[0]),
    .o_misaligned(mis_o[0]), .o_halted(halt_o[0])
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2)) u_dut2 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stall(i_stall), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_target(i_target), .i_trap(i_trap), .i_trapVec(i_trapVec),
    .i_instLen(i_instLen), .o_addr(addr_o[1]), .o_valid(valid_o[1]),
    .o_misaligned(mis_o[1]), .o_halted(halt_o[1])
  );

  // Model: mode 0 = booting, 1 = running, 2 = halted.
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mode;
    logic        mis;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t model_step(mstate_t s, int al);
    mstate_t r;
    r = s;
    r.mis = 1'b0;
    if (i_trap) begin
      r.pc   = i_trapVec - (i_trapVec % al);
      r.mode = 2'd1;
    end else if (s.mode != 2'd2) begin
      if (i_redirect) begin
        if ((i_target % al) == 0) begin
          r.pc   = i_target;
          r.mode = 2'd1;
        end else begin
          r.mode = 2'd2;
          r.mis  = 1'b1;
        end
      end else begin
        if (s.mode == 2'd1 && i_ready && !i_stall)
          r.pc = s.pc + ((al == 4 || i_instLen) ? 32'd4 : 32'd2);
        r.mode = 2'd1;
      end
    end
    return r;
  endfunction

  initial begin
    m[0] = '{pc: 32'h0, mode: 2'd0, mis: 1'b0};
    m[1] = '{pc: 32'h0, mode: 2'd0, mis: 1'b0};
  end

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m[0] <= '{pc: 32'h0, mode: 2'd0, mis: 1'b0};
      m[1] <= '{pc: 32'h0, mode: 2'd0, mis: 1'b0};
    end else begin
      m[0] <= model_step(m[0], 4);
      m[1] <= model_step(m[1], 2);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mdl_addr[%0d]", k), addr_o[k], m[k].pc);
      check($sformatf("mdl_valid[%0d]", k), 32'(valid_o[k]), 32'(m[k].mode == 2'd1));
      check($sformatf("mdl_halted[%0d]", k), 32'(halt_o[k]), 32'(m[k].mode == 2'd2));
      check($sformatf("mdl_mis[%0d]", k), 32'(mis_o[k]), 32'(m[k].mis));
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  initial begin
    tick();
    check("rst_addr", addr_o[0], 32'h0);
    check("rst_valid", 32'(valid_o[0]), 32'h0);
    check("rst_halted", 32'(halt_o[0]), 32'h0);
    tick();
    i_reset_n = 1'b1;
    check("boot_valid", 32'(valid_o[0]), 32'h0);
    tick();
    check("run0_addr", addr_o[0], 32'h0);
    check("run0_valid", 32'(valid_o[0]), 32'h1);
    tick();
    check("run1_addr", addr_o[0], 32'h4);
    tick();
    check("run2_addr", addr_o[0], 32'h8);

    // Stall two edges, then backpressure two edges.
    i_stall = 1'b1;
    tick(); check("stall1_addr", addr_o[0], 32'h8);
    tick(); check("stall2_addr", addr_o[0], 32'h8);
    i_stall = 1'b0; i_ready = 1'b0;
    tick(); check("bp1_addr", addr_o[0], 32'h8);
    tick(); check("bp2_addr", addr_o[0], 32'h8);
    i_ready = 1'b1;
    tick(); check("resume_addr", addr_o[0], 32'hC);

    // Redirect beats stall; trap beats redirect.
    i_stall = 1'b1; i_redirect = 1'b1; i_target = 32'h40;
    tick(); check("redir_stall_addr", addr_o[0], 32'h40);
    i_trap = 1'b1; i_trapVec = 32'h103;
    tick();
    check("trap_align4_addr", addr_o[0], 32'h100);
    check("trap_align2_addr", addr_o[1], 32'h102);
    i_trap = 1'b0; i_stall = 1'b0; i_redirect = 1'b0;

    // Misaligned redirect halts the word-aligned instance only.
    i_redirect = 1'b1; i_target = 32'h42;
    tick();
    check("mis_pulse", 32'(mis_o[0]), 32'h1);
    check("mis_halted", 32'(halt_o[0]), 32'h1);
    check("mis_valid", 32'(valid_o[0]), 32'h0);
    check("mis_addr_held", addr_o[0], 32'h100);
    check("half_redir_addr", addr_o[1], 32'h42);
    i_target = 32'h80;
    tick();
    check("mis_pulse_end", 32'(mis_o[0]), 32'h0);
    check("halt_ignores_redir", addr_o[0], 32'h100);
    i_redirect = 1'b0;
    tick();
    check("halt_ignores_accept", addr_o[0], 32'h100);
    i_trap = 1'b1; i_trapVec = 32'h200;
    tick();
    check("trap_exit_addr", addr_o[0], 32'h200);
    check("trap_exit_valid", 32'(valid_o[0]), 32'h1);
    check("trap_exit_halted", 32'(halt_o[0]), 32'h0);

    // Trap coinciding with a misaligned redirect.
    i_trapVec = 32'h300; i_redirect = 1'b1; i_target = 32'h42;
    tick();
    check("trap_vs_mis_addr", addr_o[0], 32'h300);
    check("trap_vs_mis_pulse", 32'(mis_o[0]), 32'h0);
    i_trap = 1'b0; i_redirect = 1'b0;

    // Compressed steps across the top of the address space.
    i_redirect = 1'b1; i_target = 32'hFFFF_FFFA;
    tick();
    check("wrap_redir_addr", addr_o[1], 32'hFFFF_FFFA);
    i_redirect = 1'b0; i_instLen = 1'b0;
    tick();
    check("wrap_step2_addr", addr_o[1], 32'hFFFF_FFFC);
    i_instLen = 1'b1;
    tick();
    check("wrap_step4_addr", addr_o[1], 32'h0000_0000);
    check("wrap_word_halted", 32'(halt_o[0]), 32'h1);

    // Asynchronous reset pulse between edges while halted.
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_addr", addr_o[0], 32'h0);
    check("async_halted", 32'(halt_o[0]), 32'h0);
    check("async_valid", 32'(valid_o[0]), 32'h0);
    #1 i_reset_n = 1'b1;
    tick();
    check("post_rst_boot_valid", 32'(valid_o[0]), 32'h0);
    tick();
    check("post_rst_run_addr", addr_o[0], 32'h0);
    tick();
    check("post_rst_step_addr", addr_o[0], 32'h4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
